instr_decode_unit: RTL and testbench

// Consumer end of the instruction queue: pops 32-bit instructions from the IQ fifo, decodes

---
 rtl/instr_decode_unit_pkg.sv | 57 +++++
 rtl/instr_decode_unit_imm_gen.sv | 38 +++
 rtl/instr_decode_unit.sv | 134 +++++++++++++
 tb/tb_instr_decode_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_unit_pkg.sv
// Shared types for the instruction decode slice: op classes, RV32I major
// opcodes, the registered decode record and the opcode classifier.
package data_types;

    typedef logic [31:0] word32_t;

    typedef enum logic [2:0] {
        OTHER   = 3'd0,
        ALU     = 3'd1,
        ALU_IMM = 3'd2,
        LOAD    = 3'd3,
        STORE   = 3'd4,
        BRANCH  = 3'd5,
        JUMP    = 3'd6,
        LUI     = 3'd7
    } op_class_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef struct packed {
        logic       valid;
        op_class_e  cls;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        word32_t    imm;
        word32_t    raw;
    } decoded_instr_t;

    function automatic op_class_e classify(input logic [6:0] opc);
        op_class_e c;
        case (opc)
            OPC_OP:            c = ALU;
            OPC_OP_IMM:        c = ALU_IMM;
            OPC_LOAD:          c = LOAD;
            OPC_STORE:         c = STORE;
            OPC_BRANCH:        c = BRANCH;
            OPC_JALR, OPC_JAL: c = JUMP;
            OPC_LUI:           c = LUI;
            default:           c = OTHER;
        endcase
        return c;
    endfunction

    function automatic logic is_ctrl(input op_class_e c);
        return (c == BRANCH) || (c == JUMP);
    endfunction

endpackage

// File: rtl/instr_decode_unit_imm_gen.sv
// Immediate extraction for RV32I formats, selected by op class.
// All formats sign-extend from instr[31].
module instr_decode_unit_imm_gen
    import data_types::*;
(
    input  logic [31:0] i_instr,
    input  op_class_e   i_class,
    output logic [31:0] o_imm
);

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};

    // Pick the format matching the class; JUMP splits into JAL (J) and JALR (I).
    always_comb begin
        o_imm = '0;
        case (i_class)
            ALU_IMM, LOAD: o_imm = w_imm_i;
            STORE:         o_imm = w_imm_s;
            BRANCH:        o_imm = w_imm_b;
            JUMP:          o_imm = (i_instr[6:0] == OPC_JAL) ? w_imm_j : w_imm_i;
            LUI:           o_imm = w_imm_u;
            default:       o_imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_unit.sv
// Instruction decode stage: pops the IQ head, decodes it into a single
// registered output stage with valid/ready to dispatch, limits the number of
// unresolved branches/jumps in flight and flushes on a mispredict.
module instr_decode_unit
    import data_types::*;
#(
    parameter int unsigned MAX_BR_INFLIGHT = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        iq_empty_i,
    input  logic [31:0] iq_instr_i,
    output logic        iq_read_o,
    input  logic        cond_eval_i,
    input  logic        corr_pred_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [2:0]  dec_class_o,
    output logic [4:0]  dec_rd_o,
    output logic [4:0]  dec_rs1_o,
    output logic [4:0]  dec_rs2_o,
    output logic [2:0]  dec_funct3_o,
    output logic [31:0] dec_imm_o,
    output logic [31:0] dec_raw_o,
    output logic        br_stall_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL_BR = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam logic [2:0] BR_MAX = 3'(MAX_BR_INFLIGHT);

    state_e         r_state;
    logic [2:0]     r_br_cnt;
    decoded_instr_t r_dec;

    op_class_e      w_head_class;
    logic [31:0]    w_head_imm;
    decoded_instr_t w_next;
    logic           w_mispredict;
    logic           w_stall_cond;
    logic           w_pop;
    logic           w_br_inc;
    logic           w_br_dec;

    assign w_head_class = classify(iq_instr_i[6:0]);

    instr_decode_unit_imm_gen u_imm_gen (
        .i_instr (iq_instr_i),
        .i_class (w_head_class),
        .o_imm   (w_head_imm)
    );

    assign w_mispredict = cond_eval_i & ~corr_pred_i;
    assign w_stall_cond = ~iq_empty_i & is_ctrl(w_head_class) & (r_br_cnt == BR_MAX);
    assign w_pop        = ~reset_i & (r_state == RUN) & ~iq_empty_i
                        & (~r_dec.valid | dec_ready_i) & ~w_stall_cond & ~w_mispredict;
    assign w_br_inc     = w_pop & is_ctrl(w_head_class);
    assign w_br_dec     = cond_eval_i & (r_br_cnt != 3'd0);

    // Build the decode record for the current IQ head.
    always_comb begin
        w_next        = '0;
        w_next.valid  = 1'b1;
        w_next.cls    = w_head_class;
        w_next.rd     = ((w_head_class == STORE) || (w_head_class == BRANCH))
                      ? 5'd0 : iq_instr_i[11:7];
        w_next.rs1    = (w_head_class == LUI) ? 5'd0 : iq_instr_i[19:15];
        w_next.rs2    = ((w_head_class == ALU) || (w_head_class == STORE) ||
                         (w_head_class == BRANCH)) ? iq_instr_i[24:20] : 5'd0;
        w_next.funct3 = iq_instr_i[14:12];
        w_next.imm    = w_head_imm;
        w_next.raw    = iq_instr_i;
    end

    // Control FSM: branch-limit stall and one-cycle flush recovery.
    // RUN only parks in STALL_BR when no resolution arrives in the same cycle;
    // otherwise the count drops and the limit is re-evaluated next cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= RUN;
        end else if (w_mispredict) begin
            r_state <= FLUSH;
        end else begin
            case (r_state)
                RUN:      if (w_stall_cond && !cond_eval_i) r_state <= STALL_BR;
                STALL_BR: if (cond_eval_i) r_state <= RUN;
                FLUSH:    r_state <= RUN;
                default:  r_state <= RUN;
            endcase
        end
    end

    // Unresolved branch/jump counter; a mispredict discards everything in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i || w_mispredict) begin
            r_br_cnt <= '0;
        end else if (w_br_inc && !w_br_dec) begin
            r_br_cnt <= r_br_cnt + 3'd1;
        end else if (w_br_dec && !w_br_inc) begin
            r_br_cnt <= r_br_cnt - 3'd1;
        end
    end

    // Output stage: load on pop, drain on accept, drop staged instr on flush.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_dec <= '0;
        end else if (w_mispredict) begin
            r_dec.valid <= 1'b0;
        end else if (w_pop) begin
            r_dec <= w_next;
        end else if (dec_ready_i) begin
            r_dec.valid <= 1'b0;
        end
    end

    assign iq_read_o    = w_pop;
    assign flush_o      = w_mispredict & ~reset_i;
    assign br_stall_o   = (r_state == STALL_BR);
    assign dec_valid_o  = r_dec.valid;
    assign dec_class_o  = r_dec.cls;
    assign dec_rd_o     = r_dec.rd;
    assign dec_rs1_o    = r_dec.rs1;
    assign dec_rs2_o    = r_dec.rs2;
    assign dec_funct3_o = r_dec.funct3;
    assign dec_imm_o    = r_dec.imm;
    assign dec_raw_o    = r_dec.raw;

endmodule

// File: tb/tb_instr_decode_unit.sv
// Directed bench for instr_decode_unit: a decode table plus hand-written
// sequences for branch-limit stall, dispatch backpressure, mispredict flush
// and reset during a stall.
module tb_instr_decode_unit;
    import data_types::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        iq_empty_i;
    logic [31:0] iq_instr_i;
    logic        iq_read_o;
    logic        cond_eval_i;
    logic        corr_pred_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [2:0]  dec_class_o;
    logic [4:0]  dec_rd_o;
    logic [4:0]  dec_rs1_o;
    logic [4:0]  dec_rs2_o;
    logic [2:0]  dec_funct3_o;
    logic [31:0] dec_imm_o;
    logic [31:0] dec_raw_o;
    logic        br_stall_o;
    logic        flush_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_BEQ  = 32'hFE000CE3;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SW   = 32'h0020A623;
    localparam logic [31:0] I_BNE  = 32'h00209463;

    instr_decode_unit #(.MAX_BR_INFLIGHT(2)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .iq_empty_i   (iq_empty_i),
        .iq_instr_i   (iq_instr_i),
        .iq_read_o    (iq_read_o),
        .cond_eval_i  (cond_eval_i),
        .corr_pred_i  (corr_pred_i),
        .dec_valid_o  (dec_valid_o),
        .dec_ready_i  (dec_ready_i),
        .dec_class_o  (dec_class_o),
        .dec_rd_o     (dec_rd_o),
        .dec_rs1_o    (dec_rs1_o),
        .dec_rs2_o    (dec_rs2_o),
        .dec_funct3_o (dec_funct3_o),
        .dec_imm_o    (dec_imm_o),
        .dec_raw_o    (dec_raw_o),
        .br_stall_o   (br_stall_o),
        .flush_o      (flush_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        op_class_e   cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, ALU_IMM, 5'd1,  5'd0,  5'd0, 3'd0, 32'h00000005};
        vecs[1]  = '{32'hFE000CE3, BRANCH,  5'd0,  5'd0,  5'd0, 3'd0, 32'hFFFFFFF8};
        vecs[2]  = '{32'h002081B3, ALU,     5'd3,  5'd1,  5'd2, 3'd0, 32'h00000000};
        vecs[3]  = '{32'hFFC12283, LOAD,    5'd5,  5'd2,  5'd0, 3'd2, 32'hFFFFFFFC};
        vecs[4]  = '{32'h0020A623, STORE,   5'd0,  5'd1,  5'd2, 3'd2, 32'h0000000C};
        vecs[5]  = '{32'hFE320FA3, STORE,   5'd0,  5'd4,  5'd3, 3'd0, 32'hFFFFFFFF};
        vecs[6]  = '{32'h00209463, BRANCH,  5'd0,  5'd1,  5'd2, 3'd1, 32'h00000008};
        vecs[7]  = '{32'h80000063, BRANCH,  5'd0,  5'd0,  5'd0, 3'd0, 32'hFFFFF000};
        vecs[8]  = '{32'h123453B7, LUI,     5'd7,  5'd0,  5'd0, 3'd5, 32'h12345000};
        vecs[9]  = '{32'h001000EF, JUMP,    5'd1,  5'd0,  5'd0, 3'd0, 32'h00000800};
        vecs[10] = '{32'hFFF280E7, JUMP,    5'd1,  5'd5,  5'd0, 3'd0, 32'hFFFFFFFF};
        vecs[11] = '{32'hFFFFFFFF, OTHER,   5'd31, 5'd31, 5'd0, 3'd7, 32'h00000000};

        // Reset with a valid head present: nothing may pop.
        reset_i     = 1'b1;
        iq_empty_i  = 1'b0;
        iq_instr_i  = I_ADDI;
        cond_eval_i = 1'b0;
        corr_pred_i = 1'b1;
        dec_ready_i = 1'b1;
        tick();
        tick();
        chk("rst.valid", dec_valid_o, 0);
        chk("rst.read", iq_read_o, 0);
        chk("rst.stall", br_stall_o, 0);
        chk("rst.flush", flush_o, 0);
        chk("rst.raw", dec_raw_o, 0);
        chk("rst.imm", dec_imm_o, 0);
        chk("rst.cls", dec_class_o, 0);

        // ADDI x1,x0,5: pop in cycle 1, decoded in cycle 2.
        reset_i = 1'b0;
        #1;
        chk("addi.read", iq_read_o, 1);
        tick();
        iq_empty_i = 1'b1;
        #1;
        chk("addi.valid", dec_valid_o, 1);
        chk("addi.cls", dec_class_o, ALU_IMM);
        chk("addi.rd", dec_rd_o, 1);
        chk("addi.imm", dec_imm_o, 5);
        chk("addi.read_empty", iq_read_o, 0);
        tick();
        chk("addi.drain", dec_valid_o, 0);

        // Decode table; control-flow entries are resolved right away.
        for (int i = 0; i < 12; i++) begin
            iq_instr_i = vecs[i].instr;
            iq_empty_i = 1'b0;
            #1;
            chk($sformatf("v%0d.read", i), iq_read_o, 1);
            tick();
            iq_empty_i  = 1'b1;
            cond_eval_i = (vecs[i].cls == BRANCH) || (vecs[i].cls == JUMP);
            corr_pred_i = 1'b1;
            #1;
            chk($sformatf("v%0d.valid", i), dec_valid_o, 1);
            chk($sformatf("v%0d.cls", i), dec_class_o, vecs[i].cls);
            chk($sformatf("v%0d.rd", i), dec_rd_o, vecs[i].rd);
            chk($sformatf("v%0d.rs1", i), dec_rs1_o, vecs[i].rs1);
            chk($sformatf("v%0d.rs2", i), dec_rs2_o, vecs[i].rs2);
            chk($sformatf("v%0d.f3", i), dec_funct3_o, vecs[i].f3);
            chk($sformatf("v%0d.imm", i), dec_imm_o, vecs[i].imm);
            chk($sformatf("v%0d.raw", i), dec_raw_o, vecs[i].instr);
            tick();
            cond_eval_i = 1'b0;
            #1;
            chk($sformatf("v%0d.drain", i), dec_valid_o, 0);
        end
        chk("table.cnt", dut.r_br_cnt, 0);

        // BEQ -8 followed by two ALU ops: one branch in flight, no stall.
        iq_instr_i = I_BEQ;
        iq_empty_i = 1'b0;
        #1;
        chk("beq.read", iq_read_o, 1);
        tick();
        iq_instr_i = I_ADD;
        #1;
        chk("beq.cls", dec_class_o, BRANCH);
        chk("beq.imm", dec_imm_o, 32'hFFFFFFF8);
        chk("beq.read_add", iq_read_o, 1);
        tick();
        iq_instr_i = I_ADDI;
        #1;
        chk("beq.add_cls", dec_class_o, ALU);
        chk("beq.read_addi", iq_read_o, 1);
        tick();
        iq_empty_i = 1'b1;
        #1;
        chk("beq.addi_cls", dec_class_o, ALU_IMM);
        chk("beq.cnt", dut.r_br_cnt, 1);
        chk("beq.stall", br_stall_o, 0);
        cond_eval_i = 1'b1;
        tick();
        cond_eval_i = 1'b0;
        #1;
        chk("beq.cnt_resolved", dut.r_br_cnt, 0);

        // Three BNE back to back: the third waits for a resolution.
        iq_instr_i = I_BNE;
        iq_empty_i = 1'b0;
        #1;
        chk("bne.read1", iq_read_o, 1);
        tick();
        chk("bne.read2", iq_read_o, 1);
        tick();
        chk("bne.read3_held", iq_read_o, 0);
        chk("bne.valid2", dec_valid_o, 1);
        tick();
        chk("bne.stall", br_stall_o, 1);
        chk("bne.read_stalled", iq_read_o, 0);
        tick();
        chk("bne.stall_hold", br_stall_o, 1);
        cond_eval_i = 1'b1;
        corr_pred_i = 1'b1;
        #1;
        chk("bne.read_resolving", iq_read_o, 0);
        tick();
        cond_eval_i = 1'b0;
        #1;
        chk("bne.unstall", br_stall_o, 0);
        chk("bne.read_resume", iq_read_o, 1);
        chk("bne.cnt1", dut.r_br_cnt, 1);
        tick();
        iq_empty_i = 1'b1;
        #1;
        chk("bne.valid3", dec_valid_o, 1);
        chk("bne.raw3", dec_raw_o, I_BNE);
        chk("bne.cnt2", dut.r_br_cnt, 2);
        cond_eval_i = 1'b1;
        tick();
        tick();
        cond_eval_i = 1'b0;
        #1;
        chk("bne.cnt_clear", dut.r_br_cnt, 0);

        // SW staged while dispatch is not ready for three cycles.
        iq_instr_i = I_SW;
        iq_empty_i = 1'b0;
        tick();
        iq_instr_i  = I_ADDI;
        dec_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("sw%0d.valid", k), dec_valid_o, 1);
            chk($sformatf("sw%0d.cls", k), dec_class_o, STORE);
            chk($sformatf("sw%0d.imm", k), dec_imm_o, 12);
            chk($sformatf("sw%0d.raw", k), dec_raw_o, I_SW);
            chk($sformatf("sw%0d.read", k), iq_read_o, 0);
            if (k < 2) tick();
        end
        chk("sw.rs1", dec_rs1_o, 1);
        chk("sw.rs2", dec_rs2_o, 2);
        dec_ready_i = 1'b1;
        #1;
        chk("sw.read_accept", iq_read_o, 1);
        tick();
        iq_empty_i = 1'b1;
        #1;
        chk("sw.next_raw", dec_raw_o, I_ADDI);
        tick();
        chk("sw.drain", dec_valid_o, 0);

        // Mispredict with a stalled, staged branch.
        iq_instr_i  = I_BEQ;
        iq_empty_i  = 1'b0;
        dec_ready_i = 1'b0;
        #1;
        chk("mp.read_beq", iq_read_o, 1);
        tick();
        iq_instr_i = I_ADD;
        #1;
        chk("mp.read_blocked", iq_read_o, 0);
        cond_eval_i = 1'b1;
        corr_pred_i = 1'b0;
        #1;
        chk("mp.flush", flush_o, 1);
        chk("mp.read_flush", iq_read_o, 0);
        tick();
        cond_eval_i = 1'b0;
        corr_pred_i = 1'b1;
        dec_ready_i = 1'b1;
        #1;
        chk("mp.flush_end", flush_o, 0);
        chk("mp.valid", dec_valid_o, 0);
        chk("mp.cnt", dut.r_br_cnt, 0);
        chk("mp.read_in_flush", iq_read_o, 0);
        tick();
        chk("mp.read_resume", iq_read_o, 1);
        tick();
        iq_empty_i = 1'b1;
        #1;
        chk("mp.add_raw", dec_raw_o, I_ADD);
        tick();

        // Pop of a branch with a concurrent resolution leaves the count unchanged.
        iq_instr_i = I_BEQ;
        iq_empty_i = 1'b0;
        tick();
        iq_instr_i  = I_BNE;
        cond_eval_i = 1'b1;
        #1;
        chk("pc.read", iq_read_o, 1);
        tick();
        cond_eval_i = 1'b0;
        #1;
        chk("pc.cnt", dut.r_br_cnt, 1);

        // Reach the branch limit again, then reset during the stall.
        chk("rs.read", iq_read_o, 1);
        tick();
        chk("rs.read_held", iq_read_o, 0);
        tick();
        chk("rs.stall", br_stall_o, 1);
        reset_i = 1'b1;
        #1;
        chk("rs.read_in_reset", iq_read_o, 0);
        tick();
        chk("rs.valid", dec_valid_o, 0);
        chk("rs.stall_clr", br_stall_o, 0);
        chk("rs.raw", dec_raw_o, 0);
        chk("rs.cls", dec_class_o, 0);
        chk("rs.rd", dec_rd_o, 0);
        chk("rs.cnt", dut.r_br_cnt, 0);
        chk("rs.flush", flush_o, 0);
        reset_i = 1'b0;
        #1;
        chk("rs.read_after", iq_read_o, 1);
        tick();
        iq_empty_i = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
